setting_digits_counter: RTL and testbench

- Parametrised two-digit BCD counter used for every time field of the clock: minutes, hours and alarm set-points.
- In run mode it advances on a timebase tick and emits a carry on wrap.
- In setting mode it is stepped up or down by debounced buttons, with press-and-hold auto-repeat.
- One instance per field; carry chains minutes to hours.

---
 rtl/setting_digits_counter.sv | 180 ++++++++++++++++++
 tb/tb_setting_digits_counter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/setting_digits_counter.sv
// Two-digit BCD field counter (minutes/hours/alarm): tick-driven in run mode, button-stepped in setting mode.
// Latency: a step decided in one cycle shows on tens/ones/carry the next cycle; at_max is combinational.
// No backpressure: tick and buttons are sampled every cycle. Optional SETTING_BLINK_EN adds the blink output.
module setting_digits_counter #(
  parameter int MODULUS       = 60,
  parameter int INIT          = 0,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int BLINK_PERIOD  = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       tick,
  input  logic       up_btn,
  input  logic       down_btn,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry,
`ifdef SETTING_BLINK_EN
  output logic       blink,
`endif
  output logic       at_max
);

  localparam int VW = $clog2(MODULUS);
  // One counter width fits every period so the repeat and blink counters share it.
  localparam int MAXP_A = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int MAXP   = (MAXP_A > BLINK_PERIOD) ? MAXP_A : BLINK_PERIOD;
  localparam int CNT_W  = $clog2(MAXP + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  localparam logic [VW-1:0]    VAL_MAX  = VW'(MODULUS - 1);
  localparam logic [VW-1:0]    VAL_INIT = VW'(INIT);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [VW-1:0]    value_q, value_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;      // 1 = the held button is up_btn
  logic             up_prev_q, dn_prev_q;
  logic             carry_q, carry_d;
  logic [3:0]       tens_q, tens_d, ones_q, ones_d;
  logic             step_up, step_dn;
  logic             rise_up, rise_dn, active_held, both_held;

  assign rise_up     = up_btn & ~up_prev_q;
  assign rise_dn     = down_btn & ~dn_prev_q;
  assign active_held = dir_q ? up_btn : down_btn;
  assign both_held   = up_btn & down_btn;
  assign at_max      = (value_q == VAL_MAX);

  // Mode/FSM decision: which step (if any) happens this cycle and the next FSM state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      step_up = tick;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise_up && !down_btn) begin
            step_up = 1'b1;
            dir_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_DELAY;
          end else if (rise_dn && !up_btn) begin
            step_dn = 1'b1;
            dir_d   = 1'b0;
            cnt_d   = '0;
            state_d = ST_DELAY;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (!active_held || both_held) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == ((state_q == ST_DELAY) ? DLY_LAST : PER_LAST)) begin
            step_up = dir_q;
            step_dn = ~dir_q;
            cnt_d   = '0;
            state_d = ST_REPEAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Modular arithmetic, wrap carry (run mode only) and BCD split of the next value.
  always_comb begin
    int v;
    value_d = value_q;
    if (step_up) begin
      value_d = at_max ? '0 : value_q + 1'b1;
    end else if (step_dn) begin
      value_d = (value_q == '0) ? VAL_MAX : value_q - 1'b1;
    end
    carry_d = ~en & tick & at_max;
    v       = int'(value_d);
    tens_d  = 4'(v / 10);
    ones_d  = 4'(v % 10);
  end

  // State registers; button history resets high so a button held through reset must be released first.
  always_ff @(posedge clk) begin
    if (!reset) begin
      value_q   <= VAL_INIT;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      up_prev_q <= 1'b1;
      dn_prev_q <= 1'b1;
      carry_q   <= 1'b0;
      tens_q    <= 4'(INIT / 10);
      ones_q    <= 4'(INIT % 10);
    end else begin
      value_q   <= value_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      up_prev_q <= up_btn;
      dn_prev_q <= down_btn;
      carry_q   <= carry_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
    end
  end

  assign tens  = tens_q;
  assign ones  = ones_q;
  assign carry = carry_q;

`ifdef SETTING_BLINK_EN
  logic             blink_q, blink_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;

  // Blink only while idling in setting mode; looking at the next state keeps digits lit from the first step.
  always_comb begin
    blink_d = 1'b0;
    bcnt_d  = '0;
    if (en && state_d == ST_IDLE) begin
      if (bcnt_q == CNT_W'(BLINK_PERIOD - 1)) begin
        blink_d = ~blink_q;
      end else begin
        blink_d = blink_q;
        bcnt_d  = bcnt_q + 1'b1;
      end
    end
  end

  // Blink phase registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_q <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      blink_q <= blink_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign blink = blink_q;
`endif

endmodule

// File: tb/tb_setting_digits_counter.sv
// Directed bench for setting_digits_counter: a MODULUS=60 and a MODULUS=24 instance with short repeat timings.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
module tb_setting_digits_counter;

  logic clk = 1'b0;
  logic reset;
  logic en, tick, up_btn, down_btn;
  logic b_en, b_tick, b_up, b_dn;
  logic [3:0] a_tens, a_ones, b_tens, b_ones;
  logic a_carry, a_at_max, b_carry, b_at_max;
`ifdef SETTING_BLINK_EN
  logic a_blink, b_blink;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  setting_digits_counter #(
    .MODULUS(60), .INIT(0), .REPEAT_DELAY(4), .REPEAT_PERIOD(2), .BLINK_PERIOD(3)
  ) u_min (
    .clk(clk), .reset(reset), .en(en), .tick(tick), .up_btn(up_btn), .down_btn(down_btn),
    .tens(a_tens), .ones(a_ones), .carry(a_carry),
`ifdef SETTING_BLINK_EN
    .blink(a_blink),
`endif
    .at_max(a_at_max)
  );

  setting_digits_counter #(
    .MODULUS(24), .INIT(0), .REPEAT_DELAY(4), .REPEAT_PERIOD(2), .BLINK_PERIOD(3)
  ) u_hr (
    .clk(clk), .reset(reset), .en(b_en), .tick(b_tick), .up_btn(b_up), .down_btn(b_dn),
    .tens(b_tens), .ones(b_ones), .carry(b_carry),
`ifdef SETTING_BLINK_EN
    .blink(b_blink),
`endif
    .at_max(b_at_max)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int val_a();
    return int'(a_tens) * 10 + int'(a_ones);
  endfunction

  function automatic int val_b();
    return int'(b_tens) * 10 + int'(b_ones);
  endfunction

  int ar_exp [12] = '{11, 11, 11, 11, 12, 12, 13, 13, 14, 14, 15, 15};
`ifdef SETTING_BLINK_EN
  int bl_exp [8]  = '{0, 0, 1, 1, 1, 0, 0, 0};
`endif

  initial begin
    reset = 1'b0; en = 1'b0; tick = 1'b0; up_btn = 1'b1; down_btn = 1'b0;
    b_en = 1'b0; b_tick = 1'b0; b_up = 1'b0; b_dn = 1'b0;

    // Reset with up_btn held
    cyc(); cyc();
    check("rst_val", val_a(), 0);
    check("rst_carry", int'(a_carry), 0);
    check("rst_atmax", int'(a_at_max), 0);
    check("rst_b_val", val_b(), 0);
    reset = 1'b1; en = 1'b1;
    cyc(); cyc();
    check("held_no_step", val_a(), 0);
    up_btn = 1'b0; en = 1'b0;
    cyc();

    // Run mode: 60 ticks, wrap with carry
    for (int i = 1; i <= 60; i++) begin
      tick = 1'b1;
      cyc();
      check("run_val", val_a(), i % 60);
      check("run_carry", int'(a_carry), (i == 60) ? 1 : 0);
      check("run_atmax", int'(a_at_max), (i == 59) ? 1 : 0);
    end
    tick = 1'b0;
    cyc();
    check("carry_clear", int'(a_carry), 0);
    check("run_hold_val", val_a(), 0);

    // Single presses in setting mode, wraps without carry
    en = 1'b1; down_btn = 1'b1;
    cyc();
    check("dn_wrap_val", val_a(), 59);
    check("dn_wrap_carry", int'(a_carry), 0);
    check("dn_wrap_atmax", int'(a_at_max), 1);
    down_btn = 1'b0;
    cyc();
    up_btn = 1'b1;
    cyc();
    check("up_wrap_val", val_a(), 0);
    check("up_wrap_carry", int'(a_carry), 0);
    up_btn = 1'b0;
    cyc();
    down_btn = 1'b1;
    cyc();
    check("dn_again_val", val_a(), 59);
    down_btn = 1'b0;
    cyc();

    // Tick up to 10; tick ignored once en rises
    en = 1'b0; tick = 1'b1;
    repeat (11) cyc();
    check("to_ten", val_a(), 10);
    en = 1'b1;
    cyc();
    check("en_rise_tick_ignored", val_a(), 10);
    tick = 1'b0;
    cyc();

    // Auto-repeat: held 12 cycles from 10
    up_btn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cyc();
      check("autorep_val", val_a(), ar_exp[c]);
      check("autorep_carry", int'(a_carry), 0);
    end
    up_btn = 1'b0;
    repeat (4) begin
      cyc();
      check("autorep_release", val_a(), 15);
    end

    // Both buttons: second press freezes
    down_btn = 1'b1;
    cyc();
    check("both_first", val_a(), 14);
    cyc();
    up_btn = 1'b1;
    repeat (8) begin
      cyc();
      check("both_frozen", val_a(), 14);
    end
    up_btn = 1'b0; down_btn = 1'b0;
    cyc();
    check("both_released", val_a(), 14);
    up_btn = 1'b1;
    cyc();
    check("both_after_up", val_a(), 15);
    up_btn = 1'b0;
    cyc(); cyc();
    check("both_after_stable", val_a(), 15);

    // Mode change mid-hold with tick
    up_btn = 1'b1;
    cyc();
    check("mc_first", val_a(), 16);
    repeat (3) cyc();
    check("mc_delay", val_a(), 16);
    cyc();
    check("mc_repeat", val_a(), 17);
    en = 1'b0; tick = 1'b1;
    cyc();
    check("mc_tick", val_a(), 18);
    tick = 1'b0;
    repeat (6) begin
      cyc();
      check("mc_run_held", val_a(), 18);
    end
    en = 1'b1;
    repeat (6) begin
      cyc();
      check("mc_set_held", val_a(), 18);
    end
    up_btn = 1'b0;
    cyc();

    // MODULUS=24 instance
    b_en = 1'b1; b_dn = 1'b1;
    cyc();
    check("m24_dn_wrap", val_b(), 23);
    check("m24_atmax_hi", int'(b_at_max), 1);
    b_dn = 1'b0; b_en = 1'b0; b_tick = 1'b1;
    cyc();
    check("m24_run_wrap", val_b(), 0);
    check("m24_carry", int'(b_carry), 1);
    check("m24_atmax_lo", int'(b_at_max), 0);
    b_tick = 1'b0;
    cyc();
    check("m24_carry_clear", int'(b_carry), 0);

`ifdef SETTING_BLINK_EN
    check("blink_run_off", int'(b_blink), 0);
    b_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      check("blink_idle", int'(b_blink), bl_exp[k]);
    end
    b_up = 1'b1;
    repeat (4) begin
      cyc();
      check("blink_hold", int'(b_blink), 0);
    end
    b_up = 1'b0; b_en = 1'b0;
    cyc();
`endif

    // Reset overrides a pending auto-repeat step
    up_btn = 1'b1;
    cyc();
    check("rst_mid_first", val_a(), 19);
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    check("rst_mid_val", val_a(), 0);
    check("rst_mid_carry", int'(a_carry), 0);
    reset = 1'b1;
    cyc(); cyc();
    check("rst_mid_held", val_a(), 0);
    up_btn = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
